// File: rtl/ssrnet_ctrl_pkg.sv
// Shared control-plane types and default timing for the OCS slot scheduler and the ToR-side VLB.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ssrnet_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_START = 2'd1,
    CMD_SYNC  = 2'd2
  } cmd_type_t;

  typedef enum logic [2:0] {
    WAIT_LINK  = 3'd0,
    SEND_START = 3'd1,
    SLOT       = 3'd2,
    CONFIG     = 3'd3,
    SEND_SYNC  = 3'd4
  } slot_state_t;

  // Default timing in core clock cycles; the ToR side must agree on these.
  localparam logic [31:0] DFLT_LINK_STABLE  = 32'd1024;
  localparam logic [31:0] DFLT_SLOT_LEN     = 32'h832;
  localparam logic [31:0] DFLT_CONFIG_DELAY = 32'h7D;

endpackage

// File: rtl/ocs_bcast_cmd.sv
// Per-channel broadcast command tracker: raises every valid on load, drops each on its own accept.
// Latency: valid rises the edge after load_i; each bit clears on the edge where valid&ready.
// Backpressure: each channel is held independently until its ready; all_done_o flags the last accept.
module ocs_bcast_cmd
  import ssrnet_ctrl_pkg::*;
#(
  parameter int P_CHANNEL_NUM = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     load_i,
  input  logic                     clr_i,
  input  logic [P_CHANNEL_NUM-1:0] ready_i,
  output logic [P_CHANNEL_NUM-1:0] valid_o,
  output logic                     all_done_o
);

  logic [P_CHANNEL_NUM-1:0] valid_q;

  // Clear wins over load so a link drop never leaves a half-sent command behind.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (load_i) begin
      valid_q <= '1;
    end else begin
      valid_q <= valid_q & ~ready_i;
    end
  end

  // Ready on an idle channel is masked off, so it never counts as an accept.
  assign all_done_o = ~|(valid_q & ~ready_i);
  assign valid_o    = valid_q;

endmodule

// File: rtl/ocs_slot_scheduler.sv
// OCS slot sequencer: waits for stable links, broadcasts START, then loops SLOT -> CONFIG -> SYNC.
// Latency: START valid one edge after the stability window; SEND lasts until the last channel accepts.
// Backpressure: SEND stalls on per-channel ready; any link drop aborts to WAIT_LINK next edge.
module ocs_slot_scheduler
  import ssrnet_ctrl_pkg::*;
#(
  parameter int          P_CHANNEL_NUM  = 8,
  parameter int          P_SLOT_NUM     = 2,
  parameter logic [31:0] P_LINK_STABLE  = DFLT_LINK_STABLE,
  parameter logic [31:0] P_SLOT_LEN     = DFLT_SLOT_LEN,
  parameter logic [31:0] P_CONFIG_DELAY = DFLT_CONFIG_DELAY,
  localparam int         P_SLOT_ID_W    = (P_SLOT_NUM > 1) ? $clog2(P_SLOT_NUM) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [P_CHANNEL_NUM-1:0] i_link_up,
  output logic [P_CHANNEL_NUM-1:0] o_cmd_valid,
  input  logic [P_CHANNEL_NUM-1:0] i_cmd_ready,
  output logic [1:0]               o_cmd_type,
  output logic [P_SLOT_ID_W-1:0]   o_cmd_slot_id,
  output logic [P_SLOT_ID_W-1:0]   o_slot_id,
  output logic                     o_in_slot,
  output logic                     o_reconfig,
  output logic [31:0]              o_slot_cnt
);

  localparam logic [P_SLOT_ID_W-1:0] LAST_SLOT_ID = P_SLOT_ID_W'(P_SLOT_NUM - 1);

  slot_state_t            state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            slot_cnt_q, slot_cnt_d;
  logic [P_SLOT_ID_W-1:0] slot_id_q, slot_id_d;
  logic                   links_ok;
  logic                   bc_load, bc_clr, bc_done;
  cmd_type_t              cmd_type;

  assign links_ok = &i_link_up;

  // State, shared phase counter, slot counter and slot id registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= WAIT_LINK;
      cnt_q      <= '0;
      slot_cnt_q <= '0;
      slot_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_cnt_q <= slot_cnt_d;
      slot_id_q  <= slot_id_d;
    end
  end

  // Next-state logic; the phase counter restarts at zero on every state entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    slot_cnt_d = slot_cnt_q;
    slot_id_d  = slot_id_q;
    bc_load    = 1'b0;
    bc_clr     = 1'b0;
    if (state_q != WAIT_LINK && !links_ok) begin
      // Link loss overrides whatever the current state wanted to do.
      state_d    = WAIT_LINK;
      cnt_d      = '0;
      slot_cnt_d = '0;
      slot_id_d  = '0;
      bc_clr     = 1'b1;
    end else begin
      case (state_q)
        WAIT_LINK: begin
          if (!links_ok) begin
            cnt_d = '0;
          end else if (cnt_q == P_LINK_STABLE - 32'd1) begin
            state_d = SEND_START;
            cnt_d   = '0;
            bc_load = 1'b1;
          end
        end
        SEND_START, SEND_SYNC: begin
          if (bc_done) begin
            state_d = SLOT;
            cnt_d   = '0;
          end
        end
        SLOT: begin
          if (cnt_q == P_SLOT_LEN - 32'd1) begin
            state_d    = CONFIG;
            cnt_d      = '0;
            slot_cnt_d = slot_cnt_q + 32'd1;
            slot_id_d  = (slot_id_q == LAST_SLOT_ID) ? '0 : slot_id_q + P_SLOT_ID_W'(1);
          end
        end
        CONFIG: begin
          if (cnt_q == P_CONFIG_DELAY - 32'd1) begin
            state_d = SEND_SYNC;
            cnt_d   = '0;
            bc_load = 1'b1;
          end
        end
        default: begin
          state_d = WAIT_LINK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Command type follows the SEND state, so it is stable for as long as any valid is high.
  always_comb begin
    cmd_type = CMD_NONE;
    if (state_q == SEND_START) cmd_type = CMD_START;
    if (state_q == SEND_SYNC)  cmd_type = CMD_SYNC;
  end

  ocs_bcast_cmd #(
    .P_CHANNEL_NUM(P_CHANNEL_NUM)
  ) u_bcast (
    .clk_i      (i_clk),
    .rst_n_i    (i_rst_n),
    .load_i     (bc_load),
    .clr_i      (bc_clr),
    .ready_i    (i_cmd_ready),
    .valid_o    (o_cmd_valid),
    .all_done_o (bc_done)
  );

  assign o_cmd_type    = cmd_type;
  assign o_cmd_slot_id = (state_q == SEND_SYNC) ? slot_id_q : '0;
  assign o_slot_id     = slot_id_q;
  assign o_in_slot     = (state_q == SLOT);
  assign o_reconfig    = (state_q == CONFIG);
  assign o_slot_cnt    = slot_cnt_q;

endmodule

// File: tb/tb_ocs_slot_scheduler.sv
// Directed bench for the OCS slot scheduler with short timing parameters.
// Latency: inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Backpressure: ready patterns are driven per test to exercise staggered accepts.
module tb_ocs_slot_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  link;
  logic [7:0]  ready;
  logic [7:0]  valid;
  logic [1:0]  ctype;
  logic        cslot;
  logic        sid;
  logic        in_slot;
  logic        reconfig;
  logic [31:0] scnt;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ocs_slot_scheduler #(
    .P_CHANNEL_NUM (8),
    .P_SLOT_NUM    (2),
    .P_LINK_STABLE (32'd8),
    .P_SLOT_LEN    (32'd16),
    .P_CONFIG_DELAY(32'd4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_link_up    (link),
    .o_cmd_valid  (valid),
    .i_cmd_ready  (ready),
    .o_cmd_type   (ctype),
    .o_cmd_slot_id(cslot),
    .o_slot_id    (sid),
    .o_in_slot    (in_slot),
    .o_reconfig   (reconfig),
    .o_slot_cnt   (scnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, ".valid"},    32'(valid),    32'h0);
    check({tag, ".type"},     32'(ctype),    32'h0);
    check({tag, ".cslot"},    32'(cslot),    32'h0);
    check({tag, ".sid"},      32'(sid),      32'h0);
    check({tag, ".in_slot"},  32'(in_slot),  32'h0);
    check({tag, ".reconfig"}, 32'(reconfig), 32'h0);
    check({tag, ".scnt"},     scnt,          32'h0);
  endtask

  // From a WAIT_LINK sample with links stable: 7 idle samples, then START on the 8th.
  task automatic expect_start(input string tag);
    tick(7);
    check({tag, ".early_valid"}, 32'(valid), 32'h0);
    tick(1);
    check({tag, ".start_valid"}, 32'(valid), 32'hFF);
    check({tag, ".start_type"},  32'(ctype), 32'h1);
    check({tag, ".start_cslot"}, 32'(cslot), 32'h0);
  endtask

  // From a SEND sample with ready=FF: 16 SLOT cycles, 4 CONFIG cycles, then the SYNC command.
  task automatic run_slot(input string tag, input logic [31:0] exp_sid, input logic [31:0] exp_cnt);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      check({tag, ".in_slot"}, 32'(in_slot), 32'h1);
      check({tag, ".slot_rc"}, 32'(reconfig), 32'h0);
      check({tag, ".slot_valid"}, 32'(valid), 32'h0);
    end
    check({tag, ".pre_sid"}, 32'(sid), (exp_sid == 0) ? 32'h1 : 32'h0);
    check({tag, ".pre_cnt"}, scnt, exp_cnt - 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check({tag, ".reconfig"}, 32'(reconfig), 32'h1);
      check({tag, ".cfg_in_slot"}, 32'(in_slot), 32'h0);
      check({tag, ".cfg_valid"}, 32'(valid), 32'h0);
    end
    check({tag, ".sid"},  32'(sid), exp_sid);
    check({tag, ".scnt"}, scnt,     exp_cnt);
    tick(1);
    check({tag, ".sync_valid"}, 32'(valid), 32'hFF);
    check({tag, ".sync_type"},  32'(ctype), 32'h2);
    check({tag, ".sync_cslot"}, 32'(cslot), exp_sid);
    check({tag, ".sync_rc"},    32'(reconfig), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    link  = 8'h00;
    ready = 8'h00;
    #23;
    chk_zero("reset");
    rst_n = 1'b1;

    // Bring-up with all links up and ready tied high.
    link  = 8'hFF;
    ready = 8'hFF;
    expect_start("bringup");
    run_slot("slot1", 32'd1, 32'd1);

    // Two more slots: slot id wraps back to 0 then 1, count reaches 3.
    run_slot("slot2", 32'd0, 32'd2);
    run_slot("slot3", 32'd1, 32'd3);
    tick(1);
    check("post_sync.type",    32'(ctype),   32'h0);
    check("post_sync.in_slot", 32'(in_slot), 32'h1);

    // Link flap on channel 3 at SLOT cycle 5.
    tick(5);
    check("flap.pre_in_slot", 32'(in_slot), 32'h1);
    link = 8'hF7;
    tick(1);
    chk_zero("flap");
    link = 8'hFF;
    expect_start("flap_restore");

    // Link loss during SEND beats the all-accept transition to SLOT.
    link = 8'h00;
    tick(1);
    chk_zero("send_loss");

    // Bring-up glitch: 5 cycles up, 1 down, then a full stability window.
    link = 8'hFF;
    tick(5);
    check("glitch.pre_valid", 32'(valid), 32'h0);
    link = 8'hFE;
    tick(1);
    check("glitch.down_valid", 32'(valid), 32'h0);
    link = 8'hFF;
    expect_start("glitch");

    // Run into CONFIG, then assert reset between clock edges.
    tick(17);
    check("rst.reconfig", 32'(reconfig), 32'h1);
    check("rst.sid",      32'(sid),      32'h1);
    tick(1);
    check("rst.scnt", scnt, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    #2;
    rst_n = 1'b1;
    ready = 8'h00;
    expect_start("restart");

    // Staggered accept: channel k ready only in SEND cycle k.
    for (int k = 0; k < 8; k++) begin
      ready = 8'(1 << k);
      tick(1);
      check("stagger.valid", 32'(valid), 32'(8'hFF & ~8'((1 << (k + 1)) - 1)));
      if (k < 7) begin
        check("stagger.type",    32'(ctype),   32'h1);
        check("stagger.in_slot", 32'(in_slot), 32'h0);
      end else begin
        check("stagger.end_type",    32'(ctype),   32'h0);
        check("stagger.end_in_slot", 32'(in_slot), 32'h1);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
